mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's MAR/MDR memory interface.
- Accepts a memory request when MFA (memory function activate) is asserted, with address from MAR and write data from MDR.
- Performs a byte, halfword or word read or write against an internal byte-addressed RAM after a fixed wait.
- Signals completion with MOC (memory operation complete) using a four-phase handshake. Read data is returned for loading into MDR.

Parameters:
- ADDR_W, 8, number of low address bits used; RAM depth is 2^ADDR_W bytes.
- LATENCY, 2, wait cycles inserted before the access is performed (0..15).

Ports:
- CLK       input   1   clock, all state updates on rising edge
- CLR       input   1   asynchronous, active-high reset
- MFA       input   1   request strobe; held high until MOC seen, then dropped
- RW        input   1   1 = read, 0 = write; sampled with MFA
- SIZE      input   2   00 byte, 01 halfword, 10 word, 11 illegal; sampled with MFA
- ADDR      input   32  byte address (MAR output); bits above ADDR_W-1 ignored
- DATA_IN   input   32  write data (MDR output); low-order bits used for byte/halfword
- DATA_OUT  output  32  read data toward MDR
- MOC       output  1   operation complete
- ERR       output  1   alignment/size error for the completed operation

Behaviour:
- Reset (CLR high, asynchronous): state IDLE, MOC=0, ERR=0, DATA_OUT=0, counter=0. RAM contents are not cleared. Reset mid-operation aborts it; a pending write is not committed.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - MFA sampled high at edge k: latch RW, SIZE, ADDR[ADDR_W-1:0] and DATA_IN; counter<=LATENCY; go WAIT.
  - Otherwise stay.
- WAIT:
  - counter!=0: decrement, stay.
  - counter==0: perform the access, go DONE, MOC<=1.
  - MFA is ignored in WAIT; latched values are used.
  - MOC is first high after edge k+LATENCY+1. LATENCY=0 gives MOC after edge k+1.
- DONE:
  - MOC=1, stay while MFA=1.
  - MFA sampled low: MOC<=0, go IDLE.
  - A new request is accepted no earlier than the edge after return to IDLE.
- Byte ordering: big-endian. Word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}. Halfword at A = {mem[A], mem[A+1]}.
- Reads:
  - DATA_OUT is updated only on completion of a read.
  - Byte and halfword reads are zero-extended into the low bits.
  - DATA_OUT holds its value across writes and idle cycles.
- Writes:
  - Byte writes store DATA_IN[7:0]; halfword writes store DATA_IN[15:0]; word writes store all 32 bits.
  - Writes affect only the addressed bytes.
- Errors:
  - Error conditions: halfword with addr[0]=1, word with addr[1:0]!=0, or SIZE=11.
  - On error: no RAM change, ERR=1 with MOC in DONE, and on reads DATA_OUT=0.
  - ERR is cleared when leaving DONE.
- Address wrap: addresses are truncated to ADDR_W bits, so 0x100 aliases to 0x00 when ADDR_W=8. Aligned accesses never straddle the top of RAM.

Optional Feature:
- Macro: MEM_SIGN_EXT_EN.
- Defined:
  - Adds input port SE (1 bit), sampled with MFA.
  - With SE=1, byte and halfword reads are sign-extended; with SE=0 they are zero-extended.
  - Word reads and writes are unaffected.
- Not defined: no SE port, and all narrow reads are zero-extended.

Test Plan:
- Handshake timing (LATENCY=2): reset, then MFA=1, RW=0, SIZE=10, ADDR=0x10, DATA_IN=0xDEADBEEF, sampled at edge k. Required: MOC rises after edge k+3 with ERR=0. Drop MFA: MOC low after the next edge, FSM returns to IDLE.
- Endianness read-back (after the 0x10 write): byte read at 0x10 gives DATA_OUT=0x000000DE. Byte read at 0x13 gives 0x000000EF. Halfword read at 0x12 gives 0x0000BEEF.
- Partial write: halfword write DATA_IN=0xAAAA1234 to 0x12, then word read at 0x10. Required: DATA_OUT=0xDEAD1234.
- Misaligned/illegal requests: word read at 0x11 gives MOC=1, ERR=1, DATA_OUT=0. Word write 0xFFFFFFFF at 0x12 gives ERR=1, and a following word read at 0x10 still returns 0xDEAD1234. SIZE=11 gives ERR=1.
- Reset mid-operation: start word write 0x01020304 to 0x20, assert CLR during WAIT. Required: MOC=0, ERR=0, DATA_OUT=0 immediately. A subsequent word read at 0x20 returns the prior contents, not 0x01020304.
- MEM_SIGN_EXT_EN build: byte read at 0x10 with SE=1 gives 0xFFFFFFDE; with SE=0 gives 0x000000DE. Halfword read at 0x10 with SE=1 gives 0xFFFFDEAD.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: latched request, fixed wait, big-endian byte RAM, MOC four-phase handshake.
// Optional build macro MEM_SIGN_EXT_EN adds the SE input for sign-extended narrow reads; fsm_state reports IDLE=0, WAIT=1, DONE=2.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
`ifdef MEM_SIGN_EXT_EN
    input  logic        SE,
`endif
    output logic [31:0] DATA_OUT,
    output logic        MOC,
    output logic        ERR,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEPTH = 1 << ADDR_W;

    // Handshake: MFA rises with a request and is held until MOC is seen;
    // MOC stays high until MFA is seen low, then the responder returns to IDLE.
    logic [1:0]        state;
    logic [3:0]        count;
    logic              l_rw;
    logic [1:0]        l_size;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_data;
    logic              l_se;

    logic [7:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] a1, a2, a3;
    logic              bad;
    logic              finish;
    logic              mem_we;
    logic [31:0]       rd_data;
    logic [7:0]        b0, b1, b2, b3;

    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDR[31:ADDR_W];

    assign fsm_state = state;

    assign a1 = l_addr + ADDR_W'(1);
    assign a2 = l_addr + ADDR_W'(2);
    assign a3 = l_addr + ADDR_W'(3);

    assign b0 = mem[l_addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    assign bad = (l_size == 2'b11)
               | ((l_size == 2'b01) & l_addr[0])
               | ((l_size == 2'b10) & (l_addr[1:0] != 2'b00));

    assign finish = (state == WAIT) && (count == 4'd0);
    assign mem_we = finish & ~l_rw & ~bad;

    always_comb begin
        rd_data = 32'd0;
        case (l_size)
            2'b00: rd_data = l_se ? {{24{b0[7]}}, b0} : {24'd0, b0};
            2'b01: rd_data = l_se ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
            2'b10: rd_data = {b0, b1, b2, b3};
            default: rd_data = 32'd0;
        endcase
    end

    // RAM is deliberately not reset; a write only fires from WAIT, which reset leaves.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            case (l_size)
                2'b00: mem[l_addr] <= l_data[7:0];
                2'b01: begin
                    mem[l_addr] <= l_data[15:8];
                    mem[a1]     <= l_data[7:0];
                end
                2'b10: begin
                    mem[l_addr] <= l_data[31:24];
                    mem[a1]     <= l_data[23:16];
                    mem[a2]     <= l_data[15:8];
                    mem[a3]     <= l_data[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            count    <= 4'd0;
            l_rw     <= 1'b0;
            l_size   <= 2'b00;
            l_addr   <= '0;
            l_data   <= 32'd0;
            l_se     <= 1'b0;
            DATA_OUT <= 32'd0;
            MOC      <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MFA) begin
                        l_rw   <= RW;
                        l_size <= SIZE;
                        l_addr <= ADDR[ADDR_W-1:0];
                        l_data <= DATA_IN;
`ifdef MEM_SIGN_EXT_EN
                        l_se   <= SE;
`else
                        l_se   <= 1'b0;
`endif
                        count  <= 4'(LATENCY);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state <= DONE;
                        MOC   <= 1'b1;
                        ERR   <= bad;
                        if (l_rw) begin
                            DATA_OUT <= bad ? 32'd0 : rd_data;
                        end
                    end
                end
                DONE: begin
                    if (!MFA) begin
                        MOC   <= 1'b0;
                        ERR   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: driver tasks push expected {err,data} into a queue, a negedge monitor pops on each MOC rise.
// The reference model is a plain byte array with big-endian assembly; MEM_SIGN_EXT_EN selects the SE variant.
module tb_mem_responder;

    localparam int AW  = 8;
    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        MFA;
    logic        RW;
    logic [1:0]  SIZE;
    logic [31:0] ADDR;
    logic [31:0] DATA_IN;
    logic        SE;
    logic [31:0] DATA_OUT;
    logic        MOC;
    logic        ERR;
    logic [1:0]  fsm_state;

    always #5 CLK = ~CLK;

    mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .CLK(CLK),
        .CLR(CLR),
        .MFA(MFA),
        .RW(RW),
        .SIZE(SIZE),
        .ADDR(ADDR),
        .DATA_IN(DATA_IN),
`ifdef MEM_SIGN_EXT_EN
        .SE(SE),
`endif
        .DATA_OUT(DATA_OUT),
        .MOC(MOC),
        .ERR(ERR),
        .fsm_state(fsm_state)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  mem_m [0:255];
    logic [31:0] last_rd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
    endfunction

    // Reference model: update the byte array / last read value, then queue the expected completion.
    task automatic model_op(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input logic se);
        int          n;
        int          base;
        logic [31:0] v;
        logic        bad;
        bad  = is_bad(sz, a);
        base = int'(a % 256);
        if (bad) begin
            if (rw) last_rd = 32'd0;
        end else begin
            n = 1 << sz;
            if (rw) begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_m[(base + i) % 256]);
`ifdef MEM_SIGN_EXT_EN
                if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
`endif
                last_rd = v;
            end else begin
                for (int i = 0; i < n; i++) mem_m[(base + i) % 256] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
            end
        end
        if (se) v = 32'd0;
        exp_q.push_back({bad, last_rd});
    endtask

    task automatic do_op(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic se);
        int cyc;
        model_op(rw, sz, a, d, se);
        @(negedge CLK);
        MFA = 1'b1; RW = rw; SIZE = sz; ADDR = a; DATA_IN = d; SE = se;
        cyc = 0;
        while (!MOC && cyc < 50) begin
            @(negedge CLK);
            cyc++;
            // Inputs other than MFA must be ignored once the request is latched.
            RW = $urandom; SIZE = 2'($urandom); ADDR = $urandom; DATA_IN = $urandom; SE = $urandom;
        end
        check("moc_latency", cyc, LAT + 2);
        MFA = 1'b0;
        @(negedge CLK);
        check("moc_drop", {31'd0, MOC}, 32'd0);
        check("err_drop", {31'd0, ERR}, 32'd0);
        check("back_to_idle", {30'd0, fsm_state}, 32'd0);
    endtask

    logic prev_moc = 1'b0;
    always @(negedge CLK) begin
        logic [32:0] e;
        if (MOC && !prev_moc) begin
            if (exp_q.size() == 0) begin
                check("unexpected_moc", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", DATA_OUT, e[31:0]);
                check("err", {31'd0, ERR}, {31'd0, e[32]});
            end
        end
        prev_moc = MOC;
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] prior;
        CLR = 1'b1; MFA = 1'b0; RW = 1'b0; SIZE = 2'b00; ADDR = 32'd0; DATA_IN = 32'd0; SE = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_moc", {31'd0, MOC}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        check("rst_data_out", DATA_OUT, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        CLR = 1'b0;

        for (int i = 0; i < 256; i += 4) do_op(1'b0, 2'b10, 32'(i), $urandom, 1'b0);

        do_op(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        do_op(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
        check("byte_rd_10", DATA_OUT, 32'h0000_00DE);
        do_op(1'b1, 2'b00, 32'h13, 32'h0, 1'b0);
        check("byte_rd_13", DATA_OUT, 32'h0000_00EF);
        do_op(1'b1, 2'b01, 32'h12, 32'h0, 1'b0);
        check("half_rd_12", DATA_OUT, 32'h0000_BEEF);
        do_op(1'b0, 2'b01, 32'h12, 32'hAAAA1234, 1'b0);
        check("wr_holds_data_out", DATA_OUT, 32'h0000_BEEF);
        do_op(1'b1, 2'b10, 32'h10, 32'h0, 1'b0);
        check("word_after_half_wr", DATA_OUT, 32'hDEAD1234);
        do_op(1'b1, 2'b10, 32'h11, 32'h0, 1'b0);
        check("misaligned_rd_zero", DATA_OUT, 32'h0);
        do_op(1'b0, 2'b10, 32'h12, 32'hFFFFFFFF, 1'b0);
        do_op(1'b1, 2'b10, 32'h10, 32'h0, 1'b0);
        check("misaligned_wr_no_change", DATA_OUT, 32'hDEAD1234);
        do_op(1'b1, 2'b11, 32'h10, 32'h0, 1'b0);
        do_op(1'b0, 2'b00, 32'h104, 32'h0000_005A, 1'b0);
        do_op(1'b1, 2'b00, 32'h04, 32'h0, 1'b0);
        check("addr_wrap", DATA_OUT, 32'h0000_005A);
`ifdef MEM_SIGN_EXT_EN
        do_op(1'b1, 2'b00, 32'h10, 32'h0, 1'b1);
        check("se_byte", DATA_OUT, 32'hFFFF_FFDE);
        do_op(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
        check("ze_byte", DATA_OUT, 32'h0000_00DE);
        do_op(1'b1, 2'b01, 32'h10, 32'h0, 1'b1);
        check("se_half", DATA_OUT, 32'hFFFF_DEAD);
`endif

        do_op(1'b0, 2'b10, 32'h20, 32'hCAFEF00D, 1'b0);
        prior = 32'hCAFEF00D;
        @(negedge CLK);
        MFA = 1'b1; RW = 1'b0; SIZE = 2'b10; ADDR = 32'h20; DATA_IN = 32'h01020304;
        @(negedge CLK);
        CLR = 1'b1; MFA = 1'b0;
        #1;
        check("midrst_moc", {31'd0, MOC}, 32'd0);
        check("midrst_err", {31'd0, ERR}, 32'd0);
        check("midrst_data_out", DATA_OUT, 32'd0);
        check("midrst_state", {30'd0, fsm_state}, 32'd0);
        last_rd = 32'd0;
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        do_op(1'b1, 2'b10, 32'h20, 32'h0, 1'b0);
        check("midrst_no_commit", DATA_OUT, prior);

        for (int i = 0; i < 80; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            do_op(1'($urandom), sz, a, $urandom, 1'($urandom));
        end

        repeat (2) @(negedge CLK);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
